counter_window_ctrl: RTL and testbench
======================================

# counter_window_ctrl

Measurement-window controller for the activity `counter` used by the power-estimation flow. It clears the counter, enables it for a programmed number of clock cycles, then drains and snapshots the final count. It also tallies counter wrap-arounds, so software gets a window activity total of `wraps * 2^CW + snapshot`. It sits between the host/config logic and one `counter` instance, owning that instance's enable and clear.

## Interface
- `CW`, 4, width of the controlled counter's count.
- `LW`, 8, width of the window-length field and of the wrap tally.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `start`  in  1  request a window; sampled only in IDLE.
- `stop`  in  1  abort request; honoured in CLEAR and RUN.
- `win_len`  in  LW  window length N in cycles; sampled with `start`.
- `count_in`  in  CW  current value from the controlled counter (registered counter output).
- `cnt_clr`  out  1  synchronous clear to the counter.
- `cnt_en`  out  1  count enable to the counter.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; results valid.
- `snapshot`  out  CW  count captured at end of window.
- `wraps`  out  LW  number of counter wraps (all-ones to 0) seen during the window.
- `aborted`  out  1  last window ended by `stop`.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, REPORT. All outputs are Moore/registered.
- IDLE, start=1, win_len!=0: latch N into `remaining`; clear `wraps` and `aborted`; go to CLEAR.
- IDLE, start=1, win_len=0: ignored; stay in IDLE with no `done` pulse.
- `start` and `stop` in the same IDLE cycle: start wins and stop is ignored.
- CLEAR (1 cycle): cnt_clr=1, cnt_en=0. If stop=1, go to DRAIN with aborted=1; otherwise go to RUN.
- RUN: cnt_en=1. `remaining` decrements each cycle.
  - Leave for DRAIN on the cycle where remaining==1.
  - stop=1 in any RUN cycle: that cycle still counts. Go to DRAIN. Set aborted=1 unless that cycle was also the last (remaining==1), in which case aborted=0.
- DRAIN (1 cycle): cnt_en=0. Lets the final increment appear on `count_in`. On exit, snapshot<=count_in. Go to REPORT.
- REPORT (1 cycle): done=1, then go to IDLE. `snapshot`, `wraps` and `aborted` hold until the next accepted `start`.
- Wrap detect: a registered copy `prev` of `count_in` is kept.
  - In RUN (excluding the first RUN cycle) and in DRAIN, prev==all-ones and count_in==0 increments `wraps`.
  - `wraps` saturates at all-ones in LW bits (unreachable for defaults: max is floor(255/16)=15).
- `start` while busy is ignored, not queued.

## Timing
- The start-sampling edge is cycle 0. CLEAR is cycle 1. RUN is cycles 2..N+1. DRAIN is N+2. REPORT (done=1) is N+3.
- Latency from `start` to `done` is N+3 cycles. Back-to-back `start` is accepted in the cycle after REPORT.
- Counter increments land on the edges ending cycles 2..N+1, so during DRAIN count_in = N mod 2^CW.
- For a full window: snapshot = N mod 2^CW and wraps = floor(N / 2^CW).
- Reset (rst low, any time, including mid-window):
  - Immediately: state=IDLE; cnt_en=0, cnt_clr=0, busy=0, done=0, snapshot=0, wraps=0, aborted=0.
  - Internal `remaining` and `prev` are also cleared.
  - Release of reset needs no extra idle cycles.

## Test plan
- Reset, then start with win_len=5. Required: cnt_clr high in cycle 1; cnt_en high in cycles 2–6; done in cycle 8; snapshot=5, wraps=0, aborted=0.
- win_len=16, then win_len=40 back-to-back (second start in the cycle after done). Required: first window gives snapshot=0, wraps=1; second gives snapshot=8, wraps=2, with done at cycle 43 of the second window.
- win_len=20, stop asserted in the 4th RUN cycle. Required: cnt_en is high for exactly 4 cycles; done 2 cycles later; snapshot=4, wraps=0, aborted=1. Stop asserted in CLEAR: snapshot=0, aborted=1.
- Edge cases:
  - Stop on the last RUN cycle (win_len=3): aborted=0, snapshot=3.
  - win_len=0 start: no busy, no done.
  - Start asserted while busy: ignored, results unchanged.
- rst pulled low in mid-RUN (win_len=100, at cycle 30), asynchronous to clk. Required: cnt_en, busy and all outputs go to 0 without waiting for a clk edge. After release, a new window with win_len=7 gives snapshot=7.
- win_len=255. Required: done at cycle 258, snapshot=15, wraps=15.

Source files
------------

// File: rtl/counter_window_ctrl_if.sv
// Host/counter-facing signal bundle for the measurement-window controller.
// The master side drives requests and the counter value; the slave side returns control and results.
interface counter_window_ctrl_if #(
  parameter int unsigned CW = 4,
  parameter int unsigned LW = 8
);
  logic          start;
  logic          stop;
  logic [LW-1:0] win_len;
  logic [CW-1:0] count_in;
  logic          cnt_clr;
  logic          cnt_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] snapshot;
  logic [LW-1:0] wraps;
  logic          aborted;

  modport master (
    output start, stop, win_len, count_in,
    input  cnt_clr, cnt_en, busy, done, snapshot, wraps, aborted
  );

  modport slave (
    input  start, stop, win_len, count_in,
    output cnt_clr, cnt_en, busy, done, snapshot, wraps, aborted
  );
endinterface

// File: rtl/counter_window_ctrl.sv
// Measurement-window controller: clears and enables an activity counter for N cycles,
// then snapshots the final count and reports how many times the counter wrapped.
module counter_window_ctrl #(
  parameter int unsigned CW = 4,
  parameter int unsigned LW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_window_ctrl_if.slave  ctrl
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] snapshot_q, snapshot_d;
  logic [LW-1:0] wraps_q, wraps_d;
  logic          aborted_q, aborted_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_en_q, cnt_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] prev_q;
  logic          wrap_arm_q;
  logic          wrap_c;

  // prev_q is only meaningful once the counter has been enabled for a cycle, which
  // excludes the first RUN cycle and a DRAIN reached straight from an aborted CLEAR.
  assign wrap_c = wrap_arm_q && ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                  (prev_q == '1) && (ctrl.count_in == '0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    snapshot_d  = snapshot_q;
    wraps_d     = wraps_q;
    aborted_d   = aborted_q;

    if (wrap_c && (wraps_q != '1)) begin
      wraps_d = wraps_q + LW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl.start && (ctrl.win_len != '0)) begin
          remaining_d = ctrl.win_len;
          wraps_d     = '0;
          aborted_d   = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (ctrl.stop) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        remaining_d = remaining_q - LW'(1);
        // A stop on the final cycle is a normal completion.
        if (remaining_q == LW'(1)) begin
          state_d = S_DRAIN;
        end else if (ctrl.stop) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        snapshot_d = ctrl.count_in;
        state_d    = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_clr_d = (state_d == S_CLEAR);
    cnt_en_d  = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      snapshot_q  <= '0;
      wraps_q     <= '0;
      aborted_q   <= 1'b0;
      cnt_clr_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prev_q      <= '0;
      wrap_arm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      snapshot_q  <= snapshot_d;
      wraps_q     <= wraps_d;
      aborted_q   <= aborted_d;
      cnt_clr_q   <= cnt_clr_d;
      cnt_en_q    <= cnt_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prev_q      <= ctrl.count_in;
      wrap_arm_q  <= (state_q == S_RUN);
    end
  end

  assign ctrl.cnt_clr  = cnt_clr_q;
  assign ctrl.cnt_en   = cnt_en_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.done     = done_q;
  assign ctrl.snapshot = snapshot_q;
  assign ctrl.wraps    = wraps_q;
  assign ctrl.aborted  = aborted_q;

endmodule

// File: tb/tb_counter_window_ctrl.sv
// Bench for counter_window_ctrl: a behavioural counter plus a window model that derives
// the enabled-cycle count from N and the stop point, then predicts timing and results.
module tb_counter_window_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_window_ctrl_if #(.CW(CW), .LW(LW)) bus ();

  counter_window_ctrl #(.CW(CW), .LW(LW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  // The controlled activity counter.
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt_q <= '0;
    else if (bus.cnt_clr) cnt_q <= '0;
    else if (bus.cnt_en)  cnt_q <= cnt_q + CW'(1);
  end
  assign bus.count_in = cnt_q;

  int total  = 0;
  int passed = 0;

  int exp_snap  = 0;
  int exp_wraps = 0;
  int exp_ab    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_results(input string tag);
    check({tag, " snapshot"}, 32'(bus.snapshot), 32'(exp_snap));
    check({tag, " wraps"},    32'(bus.wraps),    32'(exp_wraps));
    check({tag, " aborted"},  32'(bus.aborted),  32'(exp_ab));
  endtask

  // Runs one window starting in the current (negedge-aligned) cycle 0.
  // stop_at: 0 none, -1 during CLEAR, k>=1 during the k-th RUN cycle.
  task automatic run_window(input int n, input int stop_at, input bit poke, input bit stop0);
    int e;
    int en_cnt;
    int clr_cnt;
    logic [3:0] exp_ctl;
    string tag;
    if (stop_at == -1) begin
      e = 0;       exp_ab = 1;
    end else if (stop_at >= 1 && stop_at <= n) begin
      e = stop_at; exp_ab = (stop_at < n) ? 1 : 0;
    end else begin
      e = n;       exp_ab = 0;
    end
    exp_snap  = e % (1 << CW);
    exp_wraps = e / (1 << CW);
    en_cnt  = 0;
    clr_cnt = 0;
    bus.start   = 1'b1;
    bus.win_len = LW'(n);
    bus.stop    = stop0;
    for (int cyc = 1; cyc <= e + 4; cyc++) begin
      @(negedge clk);
      tag = $sformatf("n=%0d stop=%0d cyc=%0d", n, stop_at, cyc);
      exp_ctl = {cyc == 1, (cyc >= 2) && (cyc <= e + 1), cyc <= e + 3, cyc == e + 3};
      check({tag, " clr/en/busy/done"},
            32'({bus.cnt_clr, bus.cnt_en, bus.busy, bus.done}), 32'(exp_ctl));
      en_cnt  += int'(bus.cnt_en);
      clr_cnt += int'(bus.cnt_clr);
      if (cyc >= e + 3) check_results(tag);
      bus.start   = poke && (cyc <= e + 3);
      bus.win_len = LW'($urandom);
      if (stop_at == -1) bus.stop = (cyc == 1);
      else               bus.stop = (stop_at >= 1) && (cyc == stop_at + 1);
    end
    check($sformatf("n=%0d stop=%0d en cycles", n, stop_at), 32'(en_cnt), 32'(e));
    check($sformatf("n=%0d stop=%0d clr cycles", n, stop_at), 32'(clr_cnt), 32'd1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    int n;
    int mode;
    int sa;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.win_len = '0;

    #12;
    check("reset outputs",
          32'({bus.cnt_clr, bus.cnt_en, bus.busy, bus.done, bus.aborted, bus.snapshot, bus.wraps}),
          32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_window(5, 0, 1'b0, 1'b0);
    run_window(16, 0, 1'b0, 1'b0);
    run_window(40, 0, 1'b0, 1'b0);
    run_window(20, 4, 1'b0, 1'b0);
    run_window(20, -1, 1'b0, 1'b0);
    run_window(3, 3, 1'b0, 1'b0);

    // Zero-length start is ignored and leaves results untouched.
    bus.start   = 1'b1;
    bus.win_len = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("zero-len busy/done %0d", i), 32'({bus.busy, bus.done}), 32'd0);
    end
    check_results("zero-len");

    // Starts while busy and a stop alongside the accepted start are ignored.
    run_window(9, 0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a long window.
    bus.start   = 1'b1;
    bus.win_len = LW'(100);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    check("mid-run en/busy", 32'({bus.cnt_en, bus.busy}), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs",
          32'({bus.cnt_clr, bus.cnt_en, bus.busy, bus.done, bus.aborted, bus.snapshot, bus.wraps}),
          32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_window(7, 0, 1'b0, 1'b0);

    run_window(255, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      n    = $urandom_range(1, 70);
      mode = $urandom_range(0, 3);
      if (mode == 0)      sa = 0;
      else if (mode == 1) sa = -1;
      else                sa = $urandom_range(1, n + 2);
      run_window(n, sa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
